// File: rtl/ram_b1_arbiter.sv
// Two-requester round-robin arbiter in front of one ram_b1 simple dual-port RAM.
// One access (read or write) is granted per cycle. Read data returns one cycle
// later on rdata, tagged by rvalid0/rvalid1 to the requester that issued it.
// Optional grant locking for read-modify-write sequences: define RAM_ARB_LOCK_EN.
module ram_b1_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  lock0,
  input  logic                  lock1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  logic       rr_last_q;
  logic       rr_last_d;
  logic [1:0] rd_tag_q;
  logic [1:0] rd_tag_d;
  logic       elig0_c;
  logic       elig1_c;

`ifdef RAM_ARB_LOCK_EN
  localparam int unsigned CNT_W   = $clog2(LOCK_MAX + 1);
  localparam logic [1:0]  LK_NONE = 2'b00;
  localparam logic [1:0]  LK_0    = 2'b01;
  localparam logic [1:0]  LK_1    = 2'b10;

  logic [1:0]       lock_owner_q;
  logic [1:0]       lock_owner_d;
  logic [CNT_W-1:0] lock_cnt_q;
  logic [CNT_W-1:0] lock_cnt_d;
  logic [CNT_W-1:0] cnt_inc_c;

  // Lock state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_owner_q <= LK_NONE;
      lock_cnt_q   <= '0;
    end else begin
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  // Lock next state: take/extend on locked grant, release on unlock, idle owner or cap
  always_comb begin
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    cnt_inc_c    = lock_cnt_q + CNT_W'(1);
    if ((lock_owner_q == LK_0 && !req0) || (lock_owner_q == LK_1 && !req1)) begin
      lock_owner_d = LK_NONE;
      lock_cnt_d   = '0;
    end else if (gnt0 || gnt1) begin
      if ((gnt0 && lock0) || (gnt1 && lock1)) begin
        if (cnt_inc_c == CNT_W'(LOCK_MAX)) begin
          lock_owner_d = LK_NONE;
          lock_cnt_d   = '0;
        end else begin
          lock_owner_d = gnt0 ? LK_0 : LK_1;
          lock_cnt_d   = cnt_inc_c;
        end
      end else begin
        lock_owner_d = LK_NONE;
        lock_cnt_d   = '0;
      end
    end
  end

  // While locked, the other requester is masked even if the owner idles
  always_comb begin
    elig0_c = req0 && (lock_owner_q != LK_1);
    elig1_c = req1 && (lock_owner_q != LK_0);
  end
`else
  logic lock_unused;

  // Pure round-robin: lock inputs have no effect
  always_comb begin
    elig0_c = req0;
    elig1_c = req1;
  end

  assign lock_unused = ^{lock0, lock1, 32'(LOCK_MAX)};
`endif

  // Arbitration state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= 1'b1;
      rd_tag_q  <= 2'b00;
    end else begin
      rr_last_q <= rr_last_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

  // Grant: sole eligible requester wins, on contention the one not granted last wins
  always_comb begin
    gnt0 = rst_n && elig0_c && (!elig1_c || rr_last_q);
    gnt1 = rst_n && elig1_c && (!elig0_c || !rr_last_q);
  end

  // Next state: remember granted id, tag reads for the one-cycle return
  always_comb begin
    rr_last_d = rr_last_q;
    if (gnt1) begin
      rr_last_d = 1'b1;
    end else if (gnt0) begin
      rr_last_d = 1'b0;
    end
    rd_tag_d = {gnt1 && !we1, gnt0 && !we0};
  end

  // RAM port steering; ungranted cycles present requester 0's fields with we low
  always_comb begin
    ram_we    = (gnt0 && we0) || (gnt1 && we1);
    ram_waddr = gnt1 ? addr1  : addr0;
    ram_raddr = gnt1 ? addr1  : addr0;
    ram_wdata = gnt1 ? wdata1 : wdata0;
  end

  assign rvalid0 = rd_tag_q[0];
  assign rvalid1 = rd_tag_q[1];
  assign rdata   = ram_q;

endmodule

// File: tb/tb_ram_b1_arbiter.sv
// Directed bench for ram_b1_arbiter with a behavioural ram_b1 model attached.
// The RAM model reloads a fixed pattern while reset is held at a clock edge.
module tb_ram_b1_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          ram_we;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram_q;
  logic [DW-1:0] mem [64];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_b1_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_raddr(ram_raddr), .ram_wdata(ram_wdata), .ram_q(ram_q)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 5) return 8'h3C;
    return 8'(a * 7 + 3);
  endfunction

  // Behavioural ram_b1: registered read, write lands at the edge
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
    ram_q <= mem[ram_raddr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic apply_reset;
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    idle_inputs();
    req0 = 1; req1 = 1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (gnt0 !== 1'b0) begin n_err++; $display("FAIL rst_gnt0: got %b want 0", gnt0); end
    n_vec++; if (gnt1 !== 1'b0) begin n_err++; $display("FAIL rst_gnt1: got %b want 0", gnt1); end
    n_vec++; if (rvalid0 !== 1'b0) begin n_err++; $display("FAIL rst_rvalid0: got %b want 0", rvalid0); end
    n_vec++; if (rvalid1 !== 1'b0) begin n_err++; $display("FAIL rst_rvalid1: got %b want 0", rvalid1); end
    n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
    req0 = 0; req1 = 0;
    rst_n = 1;
  endtask

  task automatic test_single_read;
    req0 = 1; we0 = 0; addr0 = 6'd5;
    #1;
    n_vec++; if (gnt0 !== 1'b1) begin n_err++; $display("FAIL t1_gnt0: got %b want 1", gnt0); end
    n_vec++; if (gnt1 !== 1'b0) begin n_err++; $display("FAIL t1_gnt1: got %b want 0", gnt1); end
    n_vec++; if (ram_raddr !== 6'd5) begin n_err++; $display("FAIL t1_raddr: got %0d want 5", ram_raddr); end
    tick();
    req0 = 0;
    n_vec++; if (rvalid0 !== 1'b1) begin n_err++; $display("FAIL t1_rvalid0: got %b want 1", rvalid0); end
    n_vec++; if (rvalid1 !== 1'b0) begin n_err++; $display("FAIL t1_rvalid1: got %b want 0", rvalid1); end
    n_vec++; if (rdata !== 8'h3C) begin n_err++; $display("FAIL t1_rdata: got %h want 3c", rdata); end
    tick();
    n_vec++; if (rvalid0 !== 1'b0) begin n_err++; $display("FAIL t1_pulse: got %b want 0", rvalid0); end
  endtask

  // Previous grant went to 0, so contention starts with requester 1
  task automatic test_round_robin;
    int  c0 = 0;
    int  c1 = 0;
    logic e0, e1;
    req0 = 1; we0 = 0; addr0 = 6'd10;
    req1 = 1; we1 = 0; addr1 = 6'd20;
    for (int i = 0; i < 8; i++) begin
      e1 = (i % 2 == 0);
      e0 = !e1;
      #1;
      if (gnt0 === 1'b1) c0++;
      if (gnt1 === 1'b1) c1++;
      n_vec++; if (gnt0 !== e0 || gnt1 !== e1) begin
        n_err++; $display("FAIL rr_gnt[%0d]: got %b%b want %b%b", i, gnt1, gnt0, e1, e0);
      end
      tick();
      n_vec++; if (rvalid0 !== e0 || rvalid1 !== e1) begin
        n_err++; $display("FAIL rr_rvalid[%0d]: got %b%b want %b%b", i, rvalid1, rvalid0, e1, e0);
      end
      n_vec++; if (rdata !== (e0 ? init_val(10) : init_val(20))) begin
        n_err++; $display("FAIL rr_rdata[%0d]: got %h want %h", i, rdata, e0 ? init_val(10) : init_val(20));
      end
    end
    req0 = 0; req1 = 0;
    n_vec++; if (c0 !== 4 || c1 !== 4) begin
      n_err++; $display("FAIL rr_counts: got %0d/%0d want 4/4", c0, c1);
    end
  endtask

  task automatic test_write_then_read;
    req1 = 1; we1 = 1; addr1 = 6'd9; wdata1 = 8'hA5;
    #1;
    n_vec++; if (gnt1 !== 1'b1) begin n_err++; $display("FAIL t3_gnt1: got %b want 1", gnt1); end
    n_vec++; if (ram_we !== 1'b1 || ram_waddr !== 6'd9 || ram_wdata !== 8'hA5) begin
      n_err++; $display("FAIL t3_wport: got we=%b a=%0d d=%h want we=1 a=9 d=a5", ram_we, ram_waddr, ram_wdata);
    end
    tick();
    req1 = 0; we1 = 0;
    req0 = 1; we0 = 0; addr0 = 6'd9;
    n_vec++; if (rvalid1 !== 1'b0 || rvalid0 !== 1'b0) begin
      n_err++; $display("FAIL t3_wr_rvalid: got %b%b want 00", rvalid1, rvalid0);
    end
    #1;
    n_vec++; if (gnt0 !== 1'b1 || ram_we !== 1'b0) begin
      n_err++; $display("FAIL t3_rd_gnt: got gnt0=%b we=%b want gnt0=1 we=0", gnt0, ram_we);
    end
    tick();
    req0 = 0;
    n_vec++; if (rvalid0 !== 1'b1 || rdata !== 8'hA5) begin
      n_err++; $display("FAIL t3_raw: got rvalid0=%b rdata=%h want 1 a5", rvalid0, rdata);
    end
  endtask

  task automatic test_back_to_back;
    req0 = 1; we0 = 0;
    for (int i = 0; i < 4; i++) begin
      addr0 = 6'(i);
      #1;
      n_vec++; if (gnt0 !== 1'b1) begin n_err++; $display("FAIL b2b_gnt[%0d]: got %b want 1", i, gnt0); end
      tick();
      n_vec++; if (rvalid0 !== 1'b1 || rdata !== init_val(i)) begin
        n_err++; $display("FAIL b2b_rd[%0d]: got v=%b d=%h want v=1 d=%h", i, rvalid0, rdata, init_val(i));
      end
    end
    req0 = 0;
    tick();
    n_vec++; if (rvalid0 !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b want 0", rvalid0); end
  endtask

  task automatic test_reset_mid_read;
    req0 = 1; we0 = 0; addr0 = 6'd5;
    tick();
    n_vec++; if (rvalid0 !== 1'b1) begin n_err++; $display("FAIL mr_pre: got %b want 1", rvalid0); end
    addr0 = 6'd6;
    #1;
    rst_n = 0;
    #1;
    n_vec++; if (rvalid0 !== 1'b0 || gnt0 !== 1'b0) begin
      n_err++; $display("FAIL mr_in_rst: got rvalid0=%b gnt0=%b want 0 0", rvalid0, gnt0);
    end
    req0 = 0;
    #1;
    rst_n = 1;
    tick();
    n_vec++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
      n_err++; $display("FAIL mr_post: got %b%b want 00", rvalid1, rvalid0);
    end
    req0 = 1; req1 = 1; we1 = 0; addr0 = 6'd5; addr1 = 6'd7;
    #1;
    n_vec++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      n_err++; $display("FAIL mr_first: got %b%b want 01", gnt1, gnt0);
    end
    tick();
    req0 = 0; req1 = 0;
    n_vec++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 8'h3C) begin
      n_err++; $display("FAIL mr_read: got v=%b%b d=%h want v=01 d=3c", rvalid1, rvalid0, rdata);
    end
  endtask

`ifdef RAM_ARB_LOCK_EN
  task automatic test_lock;
    logic e0;
    apply_reset();
    req0 = 1; lock0 = 1; addr0 = 6'd1;
    req1 = 1; addr1 = 6'd2;
    for (int i = 0; i < 5; i++) begin
      e0 = (i < 4);
      #1;
      n_vec++; if (gnt0 !== e0 || gnt1 !== !e0) begin
        n_err++; $display("FAIL lock_cap[%0d]: got %b%b want %b%b", i, gnt1, gnt0, !e0, e0);
      end
      tick();
    end
    apply_reset();
    req0 = 1; lock0 = 1; addr0 = 6'd1;
    req1 = 1; addr1 = 6'd2;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) lock0 = 0;
      e0 = (i < 2);
      #1;
      n_vec++; if (gnt0 !== e0 || gnt1 !== !e0) begin
        n_err++; $display("FAIL lock_drop[%0d]: got %b%b want %b%b", i, gnt1, gnt0, !e0, e0);
      end
      tick();
    end
    idle_inputs();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_then_read();
    test_back_to_back();
    test_reset_mid_read();
`ifdef RAM_ARB_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
